// File: rtl/mem_responder.sv
// Single-port word memory answering the multicycle controller with a fixed
// number of wait states, a one-cycle ready pulse and an address-error flag.
module mem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int   WORDS    = 1 << DEPTH_LOG2;
    localparam logic LAT_ZERO = (LATENCY == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_wd;
    logic [31:0] r_rd;
    logic        r_err;
    logic [31:0] r_mem [WORDS];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_accWe;
    logic [31:0]           w_accAdr;
    logic [31:0]           w_accWd;
    logic                  w_accBad;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_accept = (r_state == IDLE) && req;
    assign w_access = (w_accept && LAT_ZERO) || ((r_state == WAIT) && (r_cnt == 4'd1));

    // With zero wait states the access happens on the accepting edge itself,
    // before the latched copies exist, so the live inputs are used then.
    assign w_accWe  = (r_state == IDLE) ? we  : r_we;
    assign w_accAdr = (r_state == IDLE) ? adr : r_adr;
    assign w_accWd  = (r_state == IDLE) ? wd  : r_wd;

    assign w_accBad = (w_accAdr[1:0] != 2'b00) ||
                      ((w_accAdr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign w_idx    = w_accAdr[DEPTH_LOG2+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        busy   = 1'b0;
        err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_next = LAT_ZERO ? RESP : WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (r_cnt == 4'd1) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                busy   = 1'b1;
                ready  = 1'b1;
                err    = r_err;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
            r_we  <= 1'b0;
            r_adr <= 32'd0;
            r_wd  <= 32'd0;
            r_rd  <= 32'd0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= 4'(LATENCY);
                r_we  <= we;
                r_adr <= adr;
                r_wd  <= wd;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_err <= w_accBad;
                if (!w_accBad && !w_accWe) begin
                    r_rd <= r_mem[w_idx];
                end
            end
        end
    end

    // Storage is deliberately not reset; a reset during WAIT suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && w_access && w_accWe && !w_accBad) begin
            r_mem[w_idx] <= w_accWd;
        end
    end

    assign rd = r_rd;

endmodule
